// File: rtl/seq_add_pkg.sv
// Shared types and defaults for the sequential slice adder.
// Holds the FSM state enum, default sizes and the counter width helper.
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W_DEF    = 4;
  localparam int NUM_SLICES_DEF = 4;

  // Slice counter width; at least one bit even for a single slice.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_slice_add_ctrl_if.sv
// Operand/result bundle of the sequential slice adder.
// master: operand source / result sink; slave: the adder controller.
// ovf is present only when SEQ_ADD_OVF_EN is defined.
interface seq_slice_add_ctrl_if #(
  parameter int W = 16
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SEQ_ADD_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SEQ_ADD_OVF_EN
    input  ovf,
`endif
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SEQ_ADD_OVF_EN
    output ovf,
`endif
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/seq_slice_add_ctrl_add_slice.sv
// add_slice: combinational SLICE_W-bit ripple adder.
// Ports: a, b, cin in; sum, cout out.
module add_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = a + b + cin;

endmodule

// File: rtl/seq_slice_add_ctrl.sv
// Wide adder built from one shared slice, LS slice first, one per cycle.
// Ports: clk, rst (async, active high), bus (slave: start/a/b/cin in;
// ready/busy/done/sum/cout out). SEQ_ADD_OVF_EN adds signed overflow ovf.
module seq_slice_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  seq_slice_add_ctrl_if.slave bus
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int CNT_W = cnt_w(NUM_SLICES);
  localparam int MSB   = SLICE_W - 1;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_c;
  logic               msb_cin;
  int                 lo;
  logic               last;
  logic               accept;

  assign lo   = int'(cnt_q) * SLICE_W;
  assign sl_a = a_q[lo +: SLICE_W];
  assign sl_b = b_q[lo +: SLICE_W];
  assign last = (cnt_q == CNT_W'(NUM_SLICES - 1));

  // Carry into the slice MSB, recovered from the sum bit.
  assign msb_cin = sl_s[MSB] ^ sl_a[MSB] ^ sl_b[MSB];

  add_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_c)
  );

  assign accept = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      RUN: begin
        sum_d[lo +: SLICE_W] = sl_s;
        carry_d = sl_c;
        if (last) begin
          cout_d  = sl_c;
          ovf_d   = msb_cin ^ sl_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
`ifdef SEQ_ADD_OVF_EN
  assign bus.ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_slice_add_ctrl.sv
// Scoreboard bench for seq_slice_add_ctrl (SLICE_W=4, NUM_SLICES=4).
// Expected results queued at issue; a negedge monitor checks each done.
module tb_seq_slice_add_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_slice_add_ctrl_if #(.W(W)) bus ();

  seq_slice_add_ctrl #(
    .SLICE_W    (4),
    .NUM_SLICES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   n_acc  = 0;
  int   n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c,
                              input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return mk(r[W-1:0], r[W],
              (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        e = q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
`ifdef SEQ_ADD_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input exp_t e);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 want 1");
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    q.push_back(e);
    n_acc++;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           n;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FFFF + 0001: latency and busy window
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    q.push_back(mk(16'h0000, 1'b1, 1'b0));
    n_acc++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("lat_busy%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("lat_nodone%0d", i), 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk("lat_done", 32'(bus.done), 32'd1);
    chk("lat_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);

    // 1234 + 4321 + 1, then hold for 10 idle cycles
    start_add(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0));
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", {14'd0, bus.done, bus.cout, bus.sum},
          {14'd0, 1'b0, 1'b0, 16'h5556});
    end

    // Back-to-back with operand churn while busy
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;
    q.push_back(mk(16'h3333, 1'b0, 1'b0));
    n_acc++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.a = 16'hAAAA;
      bus.b = 16'hAAAA;
      bus.cin = 1'b1;
    end
    @(negedge clk);
    bus.a   = 16'h0F0F;
    bus.b   = 16'h0101;
    bus.cin = 1'b1;
    q.push_back(mk(16'h1011, 1'b0, 1'b0));
    n_acc++;
    @(negedge clk);
    chk("b2b_done", 32'(bus.done), 32'd1);
    chk("b2b_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    drain();

    // Async reset at slice 2; no done, no result
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h1111;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", 32'(bus.done), 32'd0);
    end
    start_add(16'h0F0F, 16'h00F1, 1'b0, mk(16'h1000, 1'b0, 1'b0));
    drain();

    // Signed overflow corner
    start_add(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    start_add(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    drain();

    // Random sweep against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      start_add(ra, rb, rc, model(ra, rb, rc));
    end
    drain();

    chk("done_count", 32'(n_done), 32'(n_acc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
